core_sequencer: RTL and testbench

//  Multi-cycle instruction sequencer for the RV32I core. It steps every instruction through

---
 rtl/core_sequencer.sv | 164 ++++++++++++++++
 tb/tb_core_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core with memory-handshake timeout.
// Optional build macro TRAP_ILLEGAL_EN: illegal opcodes park the FSM in TRAP until reset.
`timescale 1ns/1ps
module core_sequencer #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic             branch_cond,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             ir_load,
   output logic             pc_load,
   output logic             pc_sel_target,
   output logic             reg_we,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] instret,
   output logic             bus_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_BR    = 7'b1100011;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
`ifdef TRAP_ILLEGAL_EN
      , S_TRAP = 3'd5
`endif
   } state_t;

   typedef struct packed {
      logic imem_req;
      logic dmem_req;
      logic dmem_we;
      logic ir_load;
      logic pc_load;
      logic pc_sel;
      logic reg_we;
   } strb_t;

   state_t        cur, nxt;
   strb_t         strb;
   logic [TW-1:0] tcnt, tcnt_nxt;
   logic          timeout;
   logic          retire;
   logic          is_store;

   assign is_store = (opcode == OP_STORE);

   always_comb begin
      nxt      = cur;
      strb     = '0;
      tcnt_nxt = '0;
      timeout  = 1'b0;
      case (cur)
         S_FETCH: begin
            strb.imem_req = 1'b1;
            if (imem_ready) begin
               strb.ir_load = 1'b1;
               nxt          = S_DECODE;
            end else if (tcnt == T_LAST) begin
               // abandon the fetch and step past it so the core keeps moving
               timeout      = 1'b1;
               strb.pc_load = 1'b1;
               nxt          = S_FETCH;
            end else begin
               tcnt_nxt = tcnt + TW'(1);
            end
         end
         S_DECODE: nxt = S_EXEC;
         S_EXEC: begin
            case (opcode)
               OP_LOAD, OP_STORE:        nxt = S_MEM;
               OP_R, OP_I, OP_LUI, OP_JAL: nxt = S_WB;
               OP_BR: begin
                  strb.pc_load = 1'b1;
                  strb.pc_sel  = branch_cond;
                  nxt          = S_FETCH;
               end
               default: begin
`ifdef TRAP_ILLEGAL_EN
                  nxt = S_TRAP;
`else
                  strb.pc_load = 1'b1;
                  nxt          = S_FETCH;
`endif
               end
            endcase
         end
         S_MEM: begin
            strb.dmem_req = 1'b1;
            strb.dmem_we  = is_store;
            if (dmem_ready) begin
               if (is_store) begin
                  strb.pc_load = 1'b1;
                  nxt          = S_FETCH;
               end else begin
                  nxt = S_WB;
               end
            end else if (tcnt == T_LAST) begin
               timeout      = 1'b1;
               strb.pc_load = 1'b1;
               nxt          = S_FETCH;
            end else begin
               tcnt_nxt = tcnt + TW'(1);
            end
         end
         S_WB: begin
            strb.reg_we  = 1'b1;
            strb.pc_load = 1'b1;
            strb.pc_sel  = (opcode == OP_JAL);
            nxt          = S_FETCH;
         end
`ifdef TRAP_ILLEGAL_EN
         S_TRAP: nxt = S_TRAP;
`endif
         default: nxt = S_FETCH;
      endcase
   end

   // a timed-out access moves the PC but does not count as retired
   assign retire = strb.pc_load & ~timeout;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cur     <= S_FETCH;
         tcnt    <= '0;
         instret <= '0;
         bus_err <= 1'b0;
      end else begin
         cur  <= nxt;
         tcnt <= tcnt_nxt;
         if (retire)  instret <= instret + CNT_W'(1);
         if (timeout) bus_err <= 1'b1;
      end
   end

   assign imem_req      = strb.imem_req;
   assign dmem_req      = strb.dmem_req;
   assign dmem_we       = strb.dmem_we;
   assign ir_load       = strb.ir_load;
   assign pc_load       = strb.pc_load;
   assign pc_sel_target = strb.pc_sel;
   assign reg_we        = strb.reg_we;
   assign state         = cur;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: a per-instruction phase model builds the expected
// cycle trace up front, then one process drives inputs and checks every cycle.
`timescale 1ns/1ps
module tb_core_sequencer;
   localparam int TO    = 16;
   localparam int CNT_W = 32;

   localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, T = 3'd5;
   localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RR = 7'b0110011,
                          II = 7'b0010011, LU = 7'b0110111, JL = 7'b1101111,
                          BR = 7'b1100011, IL = 7'b1111111;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, branch_cond, imem_ready, dmem_ready;
   logic [6:0]       opcode;
   logic             imem_req, dmem_req, dmem_we, ir_load, pc_load, pc_sel_target, reg_we, bus_err;
   logic [2:0]       state;
   logic [CNT_W-1:0] instret;

   core_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .branch_cond(branch_cond),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .ir_load(ir_load), .pc_load(pc_load), .pc_sel_target(pc_sel_target),
      .reg_we(reg_we), .state(state), .instret(instret), .bus_err(bus_err)
   );

   typedef struct {
      bit         rst_n, chk;
      logic [6:0] op;
      bit         ir, dr, bc;
      bit         ireq, dreq, dwe, irl, pcl, sel, rwe;
      logic [2:0] st;
      logic [31:0] cnt;
      bit         err;
   } cyc_t;

   cyc_t        q[$];
   int          n_chk = 0, n_fail = 0;
   logic [31:0] m_cnt = 0;
   bit          m_err = 0;
   logic [6:0]  m_op  = 7'd0;

   task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic push(input logic [2:0] st, input bit ir, dr, bc,
                       input bit ireq, dreq, dwe, irl, pcl, sel, rwe);
      cyc_t c;
      c.rst_n = 1; c.chk = 1; c.op = m_op; c.ir = ir; c.dr = dr; c.bc = bc;
      c.ireq = ireq; c.dreq = dreq; c.dwe = dwe; c.irl = irl; c.pcl = pcl; c.sel = sel; c.rwe = rwe;
      c.st = st; c.cnt = m_cnt; c.err = m_err;
      q.push_back(c);
   endtask

   task automatic do_reset(input int n);
      cyc_t c;
      c = '{default: 0};
      c.op = m_op;
      for (int k = 0; k < n; k++) q.push_back(c);
      m_cnt = 0;
      m_err = 0;
   endtask

   // fetch handshake: d idle-ready cycles before ready; d >= TO means ready never comes
   task automatic fetch(input int d, output bit ok);
      if (d >= TO) begin
         for (int k = 0; k < TO - 1; k++) push(F, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
         push(F, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
         m_err = 1;
         ok = 0;
      end else begin
         for (int k = 0; k < d; k++) push(F, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
         push(F, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0);
         ok = 1;
      end
   endtask

   task automatic instr(input logic [6:0] op, input int id, input int dd, input bit bc);
      bit ok;
      bit w;
      m_op = op;
      fetch(id, ok);
      if (!ok) return;
      push(D, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      case (op)
         LD, ST: begin
            w = (op == ST);
            push(E, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            if (dd >= TO) begin
               for (int k = 0; k < TO - 1; k++) push(M, 0, 0, 0, 0, 1, w, 0, 0, 0, 0);
               push(M, 0, 0, 0, 0, 1, w, 0, 1, 0, 0);
               m_err = 1;
            end else begin
               for (int k = 0; k < dd; k++) push(M, 0, 0, 0, 0, 1, w, 0, 0, 0, 0);
               if (w) begin
                  push(M, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0);
               end else begin
                  push(M, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
                  push(W, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
               end
               m_cnt++;
            end
         end
         RR, II, LU, JL: begin
            push(E, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            push(W, 0, 0, 0, 0, 0, 0, 0, 1, (op == JL), 1);
            m_cnt++;
         end
         BR: begin
            push(E, 0, 0, bc, 0, 0, 0, 0, 1, bc, 0);
            m_cnt++;
         end
         default: begin
`ifdef TRAP_ILLEGAL_EN
            push(E, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            for (int k = 0; k < 6; k++) push(T, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
            do_reset(1);
`else
            push(E, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            m_cnt++;
`endif
         end
      endcase
   endtask

   task automatic lat(input string nm, input logic [6:0] op, input bit bc, input int exp);
      int s0;
      s0 = q.size();
      instr(op, 0, 0, bc);
      chk(nm, -1, 32'(q.size() - s0), 32'(exp));
   endtask

   initial begin
      bit ok;
      rst = 0; opcode = 0; branch_cond = 0; imem_ready = 0; dmem_ready = 0;

      // build expected trace
      do_reset(2);
      lat("lat_add", RR, 0, 4);
      lat("lat_beq_taken", BR, 1, 3);
      lat("lat_beq_not", BR, 0, 3);
      lat("lat_load", LD, 0, 5);
      lat("lat_store", ST, 0, 4);
      instr(LD, 0, 3, 0);
      instr(ST, 0, 3, 0);
      instr(II, 2, 0, 0);
      instr(LU, 0, 0, 0);
      instr(JL, 1, 0, 0);
      chk("model_cnt_pin_a", -1, m_cnt, 32'd10);
      m_op = RR;
      fetch(TO, ok);
      chk("model_err_pin", -1, 32'(m_err), 32'd1);
      instr(IL, 0, 0, 0);
      instr(LD, 0, TO, 0);
      instr(RR, 15, 0, 0);
      instr(ST, 0, 15, 0);
`ifdef TRAP_ILLEGAL_EN
      chk("model_cnt_pin_b", -1, m_cnt, 32'd2);
`else
      chk("model_cnt_pin_b", -1, m_cnt, 32'd13);
`endif
      m_op = LD;
      fetch(0, ok);
      do_reset(1);
      instr(RR, 0, 0, 0);

      // drive and compare, one record per clock
      foreach (q[i]) begin
         @(posedge clk);
         #1;
         rst = q[i].rst_n; opcode = q[i].op; branch_cond = q[i].bc;
         imem_ready = q[i].ir; dmem_ready = q[i].dr;
         @(negedge clk);
         if (q[i].chk) begin
            chk("state",    i, 32'(state),    32'(q[i].st));
            chk("imem_req", i, 32'(imem_req), 32'(q[i].ireq));
            chk("dmem_req", i, 32'(dmem_req), 32'(q[i].dreq));
            if (q[i].dreq) chk("dmem_we", i, 32'(dmem_we), 32'(q[i].dwe));
            chk("ir_load",  i, 32'(ir_load),  32'(q[i].irl));
            chk("pc_load",  i, 32'(pc_load),  32'(q[i].pcl));
            if (q[i].pcl) chk("pc_sel_target", i, 32'(pc_sel_target), 32'(q[i].sel));
            chk("reg_we",   i, 32'(reg_we),   32'(q[i].rwe));
            chk("instret",  i, instret,       q[i].cnt);
            chk("bus_err",  i, 32'(bus_err),  32'(q[i].err));
         end
      end
      @(posedge clk);
      #1;
      chk("final_instret", -1, instret, 32'd1);
      chk("final_bus_err", -1, 32'(bus_err), 32'd0);
      chk("final_state",   -1, 32'(state), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
